// File: rtl/ps2_mouse_interface.sv
// ps2_mouse_interface
//   Host-side PS/2 mouse controller. After reset it inhibits the bus, sends
//   the "enable data reporting" command 0xF4, checks the mouse ACK, discards
//   the 0xFA response and then decodes 3-byte stream-mode movement packets.
//
// Ports
//   clk           system clock, all logic on its rising edge
//   reset         synchronous, active-high reset
//   ps2_clk       open-collector PS/2 clock (driven 0 or Z)
//   ps2_data      open-collector PS/2 data  (driven 0 or Z)
//   left_button   status bit0 of the last good packet
//   right_button  status bit1 of the last good packet
//   x_increment   {status[4], byte2}, 9-bit two's complement
//   y_increment   {status[5], byte3}, 9-bit two's complement
//   data_ready    a new packet is available; cleared after read is sampled high
//   read          consumer acknowledge (tie high for auto-read)
//   error_no_ack  sticky: the mouse did not acknowledge the command
//
// Build option
//   PS2_PARITY_CHECK_EN  when defined, received bytes must carry odd parity.

module ps2_mouse_interface #(
    parameter int WATCHDOG_TIMER_VALUE_PP = 19660,
    parameter int WATCHDOG_TIMER_BITS_PP  = 15,
    parameter int DEBOUNCE_TIMER_VALUE_PP = 186,
    parameter int DEBOUNCE_TIMER_BITS_PP  = 8
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    output logic       left_button,
    output logic       right_button,
    output logic [8:0] x_increment,
    output logic [8:0] y_increment,
    output logic       data_ready,
    input  logic       read,
    output logic       error_no_ack
);

    localparam logic [WATCHDOG_TIMER_BITS_PP-1:0] WD_LAST  = WATCHDOG_TIMER_BITS_PP'(WATCHDOG_TIMER_VALUE_PP - 1);
    localparam logic [WATCHDOG_TIMER_BITS_PP-1:0] REQ_LAST = WATCHDOG_TIMER_BITS_PP'(DEBOUNCE_TIMER_VALUE_PP - 1);
    localparam logic [DEBOUNCE_TIMER_BITS_PP-1:0] DEB_LAST = DEBOUNCE_TIMER_BITS_PP'(DEBOUNCE_TIMER_VALUE_PP - 1);

    localparam logic [7:0] CMD_ENABLE_STREAM = 8'hF4;
    // Bits shifted out after the start bit: data LSB first, odd parity, stop.
    localparam logic [9:0] TX_FRAME = {1'b1, ~^CMD_ENABLE_STREAM, CMD_ENABLE_STREAM};

    typedef enum logic [1:0] {CLK_H, FALL, CLK_L, RISE} edge_state_t;
    typedef enum logic [2:0] {INHIBIT, REQ, TX, WAIT_ACK, RESP, STREAM} host_state_t;

    // ---------------- input synchronizers ----------------
    logic clk_s1, clk_sync, data_s1, data_sync;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours (the 2-FF chain depends on it).
    always_ff @(posedge clk) begin
        if (reset) begin
            // Idle bus level is high, so no spurious edge is seen after reset.
            clk_s1    <= 1'b1;
            clk_sync  <= 1'b1;
            data_s1   <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_s1    <= ps2_clk;
            clk_sync  <= clk_s1;
            data_s1   <= ps2_data;
            data_sync <= data_s1;
        end
    end

    // ---------------- debounced clock edge FSM ----------------
    edge_state_t                     edge_state, edge_next;
    logic [DEBOUNCE_TIMER_BITS_PP-1:0] deb_cnt;
    logic                            deb_active, deb_done, fall_strobe;

    // Counting only while the synchronized level disagrees with the FSM level.
    assign deb_active = (edge_state == CLK_H && !clk_sync) || (edge_state == CLK_L && clk_sync);
    assign deb_done   = deb_active && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk) begin
        if (reset) edge_state <= CLK_H;
        else       edge_state <= edge_next;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        edge_next = edge_state;
        case (edge_state)
            CLK_H:   if (deb_done) edge_next = FALL;
            FALL:    edge_next = CLK_L;
            CLK_L:   if (deb_done) edge_next = RISE;
            RISE:    edge_next = CLK_H;
            default: edge_next = CLK_H;
        endcase
    end

    always_comb begin
        fall_strobe = (edge_state == FALL);
    end

    always_ff @(posedge clk) begin
        if (reset || !deb_active || deb_done) deb_cnt <= '0;
        else                                  deb_cnt <= deb_cnt + 1'b1;
    end

    // ---------------- host FSM ----------------
    host_state_t                       state, state_next;
    logic [WATCHDOG_TIMER_BITS_PP-1:0] wd_cnt;
    logic                              wd_expired;
    logic [5:0]                        bit_count;
    logic [9:0]                        tx_shift;
    logic                              tx_bit;
    logic                              clk_drive_low, data_drive_low;

    assign wd_expired = (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= INHIBIT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INHIBIT:  if (wd_expired) state_next = REQ;
            REQ:      if (wd_cnt == REQ_LAST) state_next = TX;
            TX:       if (wd_expired) state_next = STREAM;
                      else if (fall_strobe && bit_count == 6'd9) state_next = WAIT_ACK;
            // A missing ACK skips the response frame: none is expected.
            WAIT_ACK: if (wd_expired) state_next = STREAM;
                      else if (fall_strobe) state_next = data_sync ? STREAM : RESP;
            // The response frame is consumed whatever its content.
            RESP:     if (fall_strobe && bit_count == 6'd10) state_next = STREAM;
            STREAM:   state_next = STREAM;
            default:  state_next = INHIBIT;
        endcase
    end

    // Lines are released while reset is held; inhibit starts on reset exit.
    always_comb begin
        clk_drive_low  = 1'b0;
        data_drive_low = 1'b0;
        if (!reset) begin
            case (state)
                INHIBIT: clk_drive_low = 1'b1;
                REQ: begin
                    clk_drive_low  = 1'b1;
                    data_drive_low = 1'b1;
                end
                TX:      data_drive_low = !tx_bit;
                default: ;
            endcase
        end
    end

    assign ps2_clk  = clk_drive_low  ? 1'b0 : 1'bz;
    assign ps2_data = data_drive_low ? 1'b0 : 1'bz;

    // Watchdog: restarts on every state change and every accepted falling edge.
    always_ff @(posedge clk) begin
        if (reset || state_next != state || fall_strobe || wd_expired) wd_cnt <= '0;
        else                                                           wd_cnt <= wd_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || state_next != state) begin
            bit_count <= '0;
        end else if ((state == TX || state == RESP || state == STREAM) && fall_strobe) begin
            bit_count <= (state == STREAM && bit_count == 6'd32) ? 6'd0 : bit_count + 6'd1;
        end else if ((state == RESP || state == STREAM) && wd_expired && bit_count != 6'd0) begin
            // Stalled partial frame: drop it and realign on the next start bit.
            bit_count <= '0;
        end
    end

    // tx_bit = 0 while entering TX presents the start bit behind the REQ drive.
    always_ff @(posedge clk) begin
        if (reset || state == INHIBIT || state == REQ) begin
            tx_shift <= TX_FRAME;
            tx_bit   <= 1'b0;
        end else if (state == TX && fall_strobe) begin
            tx_bit   <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[9:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_no_ack <= 1'b0;
        end else if (((state == TX || state == WAIT_ACK) && wd_expired) ||
                     (state == WAIT_ACK && fall_strobe && data_sync)) begin
            error_no_ack <= 1'b1;
        end
    end

    // ---------------- receive and packet decode ----------------
    logic [31:0] rx_shift;
    logic [32:0] rx_next;
    logic        packet_done, frame_ok, parity_ok;
    logic        unused_rx_bits;

    // rx_next[0] is the oldest bit; byte k spans rx_next[11k +: 11].
    assign rx_next     = {data_sync, rx_shift};
    assign packet_done = (state == STREAM) && fall_strobe && (bit_count == 6'd32);
    assign frame_ok    = !rx_next[0]  && rx_next[10] &&
                         !rx_next[11] && rx_next[21] &&
                         !rx_next[22] && rx_next[32] &&
                         rx_next[4];                      // status bit3 is always 1
`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok   = (^rx_next[9:1]) && (^rx_next[20:12]) && (^rx_next[31:23]);
`else
    assign parity_ok   = 1'b1;
`endif
    // Middle button, overflow flags and (by default) parity bits are not decoded.
    assign unused_rx_bits = ^{rx_next[3], rx_next[8:7], rx_next[9], rx_next[20], rx_next[31]};

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift <= '0;
        end else if ((state == RESP || state == STREAM) && fall_strobe) begin
            rx_shift <= rx_next[32:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_button  <= 1'b0;
            right_button <= 1'b0;
            x_increment  <= '0;
            y_increment  <= '0;
            data_ready   <= 1'b0;
        end else if (packet_done && frame_ok && parity_ok) begin
            left_button  <= rx_next[1];
            right_button <= rx_next[2];
            x_increment  <= {rx_next[5], rx_next[19:12]};
            y_increment  <= {rx_next[6], rx_next[30:23]};
            data_ready   <= 1'b1;
        end else if (read) begin
            data_ready   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_interface.sv
// tb_ps2_mouse_interface
//   Directed bench for ps2_mouse_interface with a behavioural PS/2 mouse:
//   handshake/ACK, 0xFA response, movement packets, malformed packets,
//   partial-packet timeout, read handshake, missing ACK and reset behaviour.

`timescale 1ns/1ps

module tb_ps2_mouse_interface;

    localparam int WD  = 200;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       read = 1'b1;
    wire        ps2_clk;
    wire        ps2_data;
    logic       left_button, right_button, data_ready, error_no_ack;
    logic [8:0] x_increment, y_increment;

    logic m_clk_low  = 1'b0;
    logic m_data_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = m_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = m_data_low ? 1'b0 : 1'bz;

    ps2_mouse_interface #(
        .WATCHDOG_TIMER_VALUE_PP (WD),
        .WATCHDOG_TIMER_BITS_PP  (8),
        .DEBOUNCE_TIMER_VALUE_PP (DEB),
        .DEBOUNCE_TIMER_BITS_PP  (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .left_button  (left_button),
        .right_button (right_button),
        .x_increment  (x_increment),
        .y_increment  (y_increment),
        .data_ready   (data_ready),
        .read         (read),
        .error_no_ack (error_no_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // data_ready rising edges and high cycles, sampled on the falling edge.
    int   ready_count = 0;
    int   high_cycles = 0;
    logic dr_prev = 1'b0;
    always @(negedge clk) begin
        if (data_ready && !dr_prev) ready_count++;
        if (data_ready) high_cycles++;
        dr_prev = data_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One device-clocked bit: data set while clock high, 150 ns low phase.
    task automatic send_bit(input logic b);
        m_data_low = ~b;
        #75  m_clk_low = 1'b1;
        #150 m_clk_low = 1'b0;
        #75;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        m_data_low = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b1, 1'b0, 1'b0);
        send_byte(b2, 1'b0, 1'b0);
        send_byte(b3, 1'b0, 1'b0);
    endtask

    // Waits for the host inhibit, measures it, then clocks the 11-bit
    // host-to-device frame. seen[0] is the start bit, seen[i] is sampled
    // just before rising edge i.
    task automatic mouse_handshake(input logic give_ack, output logic [10:0] seen, output int low_cycles);
        int waited;
        waited     = 0;
        low_cycles = 0;
        seen       = '0;
        while (ps2_clk !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        while (ps2_clk === 1'b0 && low_cycles < 2000) begin
            @(negedge clk);
            low_cycles++;
        end
        #200;
        seen[0] = ps2_data;
        for (int i = 1; i <= 10; i++) begin
            #75  m_clk_low = 1'b1;
            #140 seen[i] = ps2_data;
            #10  m_clk_low = 1'b0;
            #75;
        end
        m_data_low = give_ack;
        #75  m_clk_low = 1'b1;
        #150 m_clk_low = 1'b0;
        m_data_low = 1'b0;
        #75;
    endtask

    initial begin
        #3ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [10:0] seen;
        int          low;
        int          base;
        int          hc;

        // ---- reset state ----
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_left", left_button, 1'b0);
        check("rst_right", right_button, 1'b0);
        check("rst_x", x_increment, 9'h000);
        check("rst_y", y_increment, 9'h000);
        check("rst_err", error_no_ack, 1'b0);
        check("rst_ps2_clk_released", ps2_clk, 1'b1);
        check("rst_ps2_data_released", ps2_data, 1'b1);

        // ---- command 0xF4 and ACK ----
        reset = 1'b0;
        mouse_handshake(1'b1, seen, low);
        check("inhibit_len_ok", (low >= WD) && (low <= WD + DEB + 8), 1'b1);
        check("tx_start", seen[0], 1'b0);
        check("tx_cmd", seen[8:1], 8'hF4);
        check("tx_parity", seen[9], 1'b0);
        check("tx_stop", seen[10], 1'b1);
        repeat (20) @(negedge clk);
        check("ack_err", error_no_ack, 1'b0);

        // ---- 0xFA response frame: discarded ----
        send_byte(8'hFA, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("resp_no_ready", ready_count, 0);

        // ---- packet 0x28,0x05,0xFF ----
        base = ready_count;
        hc   = high_cycles;
        send_packet(8'h28, 8'h05, 8'hFF);
        repeat (20) @(negedge clk);
        check("p1_pulse", ready_count - base, 1);
        check("p1_pulse_width", high_cycles - hc, 1);
        check("p1_left", left_button, 1'b0);
        check("p1_right", right_button, 1'b0);
        check("p1_x", x_increment, 9'h005);
        check("p1_y", y_increment, 9'h1FF);

        // ---- packet 0x19,0xF6,0x14 ----
        base = ready_count;
        send_packet(8'h19, 8'hF6, 8'h14);
        repeat (20) @(negedge clk);
        check("p2_pulse", ready_count - base, 1);
        check("p2_left", left_button, 1'b1);
        check("p2_x", x_increment, 9'h1F6);
        check("p2_y", y_increment, 9'h014);

        // ---- packet 0x0A,0x00,0x00 ----
        send_packet(8'h0A, 8'h00, 8'h00);
        repeat (20) @(negedge clk);
        check("p3_right", right_button, 1'b1);
        check("p3_left", left_button, 1'b0);
        check("p3_x", x_increment, 9'h000);
        check("p3_y", y_increment, 9'h000);

        // ---- packet 0x28,0x7F,0x80: extreme magnitudes ----
        send_packet(8'h28, 8'h7F, 8'h80);
        repeat (20) @(negedge clk);
        check("p4_x", x_increment, 9'h07F);
        check("p4_y", y_increment, 9'h180);

        // ---- status bit3 clear: dropped ----
        base = ready_count;
        send_packet(8'h21, 8'h01, 8'h01);
        repeat (20) @(negedge clk);
        check("bit3_no_ready", ready_count - base, 0);
        check("bit3_hold_x", x_increment, 9'h07F);
        check("bit3_hold_y", y_increment, 9'h180);

        // ---- bad stop bit in byte 3: dropped ----
        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("stop_no_ready", ready_count - base, 0);
        check("stop_hold_x", x_increment, 9'h07F);

        // ---- partial packet dropped by watchdog, next packet aligned ----
        send_byte(8'h09, 1'b0, 1'b0);
        repeat (3 * WD) @(negedge clk);
        send_packet(8'h09, 8'h03, 8'h04);
        repeat (20) @(negedge clk);
        check("gap_pulse", ready_count - base, 1);
        check("gap_left", left_button, 1'b1);
        check("gap_x", x_increment, 9'h003);
        check("gap_y", y_increment, 9'h004);

        // ---- read handshake and overwrite while pending ----
        read = 1'b0;
        send_packet(8'h0A, 8'h10, 8'h20);
        repeat (20) @(negedge clk);
        check("hold_ready", data_ready, 1'b1);
        check("hold_x", x_increment, 9'h010);
        send_packet(8'h29, 8'h02, 8'h03);
        repeat (20) @(negedge clk);
        check("ovw_ready", data_ready, 1'b1);
        check("ovw_left", left_button, 1'b1);
        check("ovw_x", x_increment, 9'h002);
        check("ovw_y", y_increment, 9'h103);
        read = 1'b1;
        @(negedge clk);
        check("read_clears", data_ready, 1'b0);

`ifdef PS2_PARITY_CHECK_EN
        // ---- wrong parity on byte 2: dropped ----
        base = ready_count;
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("par_no_ready", ready_count - base, 0);
        check("par_hold_x", x_increment, 9'h002);
        check("par_hold_y", y_increment, 9'h103);
`endif

        // ---- reset mid-packet, then missing ACK ----
        send_byte(8'h08, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst2_x", x_increment, 9'h000);
        check("rst2_ps2_clk_released", ps2_clk, 1'b1);
        reset = 1'b0;
        mouse_handshake(1'b0, seen, low);
        check("rst2_cmd", seen[8:1], 8'hF4);
        repeat (20) @(negedge clk);
        check("noack_err", error_no_ack, 1'b1);

        base = ready_count;
        send_packet(8'h28, 8'h01, 8'h02);
        repeat (20) @(negedge clk);
        check("noack_stream_pulse", ready_count - base, 1);
        check("noack_stream_x", x_increment, 9'h001);
        check("noack_stream_y", y_increment, 9'h102);
        check("noack_err_sticky", error_no_ack, 1'b1);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst3_err", error_no_ack, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_interface.md
# ps2_mouse_interface

Host-side PS/2 mouse controller. It drives the open-collector PS/2 clock/data lines, enables stream mode after reset by sending command 0xF4, and then receives 3-byte movement packets. Each packet is decoded into button states and 9-bit two's-complement X/Y increments for the drawing/cursor logic. It sits between the board's PS/2 pins (with external pull-ups) and the application fabric, in a single clock domain.

## Interface
- WATCHDOG_TIMER_VALUE_PP, 19660: cycles for bus inhibit, edge timeout and frame-gap timeout. Must be at least 100 µs; use 10800 at 27 MHz.
- WATCHDOG_TIMER_BITS_PP, 15: width of the watchdog counter.
- DEBOUNCE_TIMER_VALUE_PP, 186: cycles a ps2_clk level must be stable before an edge is accepted. Use 100 at 27 MHz.
- DEBOUNCE_TIMER_BITS_PP, 8: width of the debounce counter.

Ports:
- clk  in  1  system clock. One clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  inout  1  open-collector. Drives 0 or Z, never 1.
- ps2_data  inout  1  open-collector. Drives 0 or Z, never 1.
- left_button  out  1  status bit0 of the last good packet.
- right_button  out  1  status bit1 of the last good packet.
- x_increment  out  9  {status[4], byte2}, two's complement.
- y_increment  out  9  {status[5], byte3}, two's complement.
- data_ready  out  1  a new packet is available.
- read  in  1  consumer acknowledge. Tie to 1 for auto-read.
- error_no_ack  out  1  sticky error: the mouse did not acknowledge the command.

## Operation
- Input sampling
  - ps2_clk and ps2_data pass through 2-FF synchronizers.
  - The clock edge FSM has states CLK_H, FALL, CLK_L, RISE.
  - A level change must hold for DEBOUNCE_TIMER_VALUE_PP cycles to be accepted.
  - FALL and RISE each last exactly one cycle and act as edge strobes.
- Host FSM, transmit phase
  - INHIBIT: on reset exit, drive ps2_clk low for WATCHDOG_TIMER_VALUE_PP cycles.
  - REQ: drive ps2_data low. After DEBOUNCE_TIMER_VALUE_PP further cycles, release ps2_clk.
  - TX: on each debounced falling edge, present the next bit: 0xF4 bits 0..7 LSB first, then odd parity (0 for 0xF4), then release data as the stop bit (1).
  - WAIT_ACK: at the 11th falling edge, ps2_data must be 0.
    - If data is 1, or no falling edge arrives within WATCHDOG_TIMER_VALUE_PP cycles at any point in TX/WAIT_ACK, set error_no_ack.
    - Then release both lines and go to STREAM.
  - RESP: receive one 11-bit frame (expected 0xFA) and discard it. It never raises data_ready.
- Host FSM, receive phase
  - STREAM: shift in 33 bits, LSB-first, on debounced falling edges.
  - A bit counter tracks position in the packet. If the counter is nonzero and no falling edge arrives for WATCHDOG_TIMER_VALUE_PP cycles, the counter clears and the partial packet is dropped.
- Packet validation
  - Each byte's start bit must be 0 and its stop bit 1.
  - Status bit3 must be 1.
  - A failing packet is dropped silently and its outputs are unchanged.
- Packet output
  - On a good packet, latch left_button, right_button, x_increment and y_increment, and set data_ready.
  - data_ready clears on the cycle after read is sampled high. With read=1 it is a 1-cycle pulse.
  - A new packet arriving while data_ready is still high overwrites the outputs and keeps data_ready high.
- error_no_ack stays set until reset. Stream reception continues after the error.

## Timing
- Reset values:
  - all outputs 0;
  - ps2_clk and ps2_data released (Z);
  - counters 0;
  - FSM returns to INHIBIT.
- Reset in the middle of any transfer aborts it and restarts the whole 0xF4 sequence.
- Edge recognition latency is DEBOUNCE_TIMER_VALUE_PP + 2 cycles after the pin transition.
- Transmit data changes within 1 cycle of the FALL strobe, well inside the clock-low half.
- Outputs update, and data_ready rises, 1 cycle after the FALL strobe of the 33rd bit.
- Gaps between bytes are tolerated up to the watchdog period.

## Configuration
- PS2_PARITY_CHECK_EN
  - Defined: each received byte (including the 0xFA response) must carry odd parity. A packet with any parity failure is dropped; a bad response frame is ignored.
  - Undefined: parity bits are shifted in and ignored.
- Transmit parity is always generated, with or without the macro.

## Test plan
- Command and ACK
  - Stimulus: release reset; the mouse model waits for ps2_clk low, then clocks 11 pulses and drives ACK low.
  - Response: ps2_clk is held low for at least WATCHDOG_TIMER_VALUE_PP cycles; command 0xF4, parity 0 and stop 1 are received; error_no_ack stays 0.
- 0xFA response
  - Stimulus: the mouse sends 0xFA.
  - Response: no data_ready pulse.
- Packet 0x28,0x05,0xFF
  - Response: data_ready pulse, LB=0, RB=0, x=0x005 (+5), y=0x1FF (−1).
- Packet 0x19,0xF6,0x14, then packet 0x0A,0x00,0x00
  - Response to the first: LB=1, x=0x1F6 (−10), y=0x014 (+20).
  - Response to the second: RB=1, LB=0, x=0, y=0.
- Packet 0x28,0x7F,0x80
  - Response: x=0x07F (+127), y=0x180 (−128).
- No ACK
  - Stimulus: the mouse leaves data high on the 11th pulse.
  - Response: error_no_ack=1 and it stays 1 until reset.
- Bad parity (PS2_PARITY_CHECK_EN defined)
  - Stimulus: a packet byte with a wrong parity bit.
  - Response: no data_ready; outputs hold their previous values.
